// File: rtl/riscv_cpu_axi_pkg.sv
// riscv_cpu_axi_pkg: AXI response codes, control-bank byte offsets and FSM encodings
// shared by the PS-facing control slave.
package riscv_cpu_axi_pkg;
   localparam logic [1:0] OKAY   = 2'b00;
   localparam logic [1:0] SLVERR = 2'b10;
   localparam int CTRL_CORE_RST = 'h0;
   localparam int CTRL_STATUS   = 'h4;
   localparam int CTRL_SCRATCH  = 'h8;
   typedef enum logic [1:0] {W_IDLE, W_EXEC, W_RESP} w_state_e;
   typedef enum logic [1:0] {R_IDLE, R_ISSUE, R_WAIT, R_DATA} r_state_e;
endpackage

// File: rtl/riscv_rst_sync.sv
// riscv_rst_sync: per-core reset, asserted asynchronously by arst or on the clock after
// hold_in rises, released only after STAGES consecutive clocks with hold_in low.
module riscv_rst_sync #(
   parameter int STAGES = 2
) (
   input  logic clk,
   input  logic arst,
   input  logic hold_in,
   output logic rst_out
);
   logic [STAGES-1:0] r_chain;
   always_ff @(posedge clk or posedge arst)
      if (arst) r_chain <= '1;
      else      r_chain <= hold_in ? '1 : {r_chain[STAGES-2:0], 1'b0};
   assign rst_out = r_chain[STAGES-1];
endmodule

// File: rtl/riscv_cpu_axi_ctrl.sv
// riscv_cpu_axi_ctrl: AXI4-Lite slave splitting the PS address space into a shared CPU
// memory window (top address bit 0) and a control bank with per-core reset (top bit 1).
module riscv_cpu_axi_ctrl
   import riscv_cpu_axi_pkg::*;
#(
   parameter int ADDR_WIDTH      = 14,
   parameter int DATA_WIDTH      = 32,
   parameter int NUM_CORES       = 1,
   parameter int RST_SYNC_STAGES = 2
) (
   input  logic                                       riscv_cpu_clk,
   input  logic                                       riscv_cpu_reset,
   input  logic [ADDR_WIDTH-1:0]                      axi_if_awaddr,
   input  logic                                       axi_if_awvalid,
   output logic                                       axi_if_awready,
   input  logic [DATA_WIDTH-1:0]                      axi_if_wdata,
   input  logic [DATA_WIDTH/8-1:0]                    axi_if_wstrb,
   input  logic                                       axi_if_wvalid,
   output logic                                       axi_if_wready,
   output logic [1:0]                                 axi_if_bresp,
   output logic                                       axi_if_bvalid,
   input  logic                                       axi_if_bready,
   input  logic [ADDR_WIDTH-1:0]                      axi_if_araddr,
   input  logic                                       axi_if_arvalid,
   output logic                                       axi_if_arready,
   output logic [DATA_WIDTH-1:0]                      axi_if_rdata,
   output logic [1:0]                                 axi_if_rresp,
   output logic                                       axi_if_rvalid,
   input  logic                                       axi_if_rready,
   output logic [ADDR_WIDTH-2-$clog2(DATA_WIDTH/8):0] mem_addr,
   output logic                                       mem_wen,
   output logic [DATA_WIDTH/8-1:0]                    mem_wstrb,
   output logic [DATA_WIDTH-1:0]                      mem_wdata,
   output logic                                       mem_ren,
   input  logic [DATA_WIDTH-1:0]                      mem_rdata,
   output logic [NUM_CORES-1:0]                       core_reset
);
   localparam int NB  = DATA_WIDTH/8;
   localparam int LSB = $clog2(NB);
   localparam int OW  = ADDR_WIDTH-3;
   w_state_e              r_wstate;
   r_state_e              r_rstate;
   logic                  r_aw_held, r_w_held, r_awready, r_wready, r_bvalid, r_arready, r_rvalid;
   logic [1:0]            r_bresp, r_rresp;
   logic [ADDR_WIDTH-1:0] r_awaddr, r_araddr;
   logic [DATA_WIDTH-1:0] r_wdata, r_rdata, r_scratch;
   logic [NB-1:0]         r_wstrb;
   logic [NUM_CORES-1:0]  r_core_rst, w_core_reset;
   logic [DATA_WIDTH-1:0] w_bmask, w_ctrl_rdata;
   logic                  w_aw_hs, w_w_hs, w_aw_next, w_w_next, w_mem_wen, w_mem_ren, w_unused;
   logic                  w_wr_ctrl, w_wr_rst, w_wr_scr, w_rd_ctrl, w_rd_rst, w_rd_sts, w_rd_scr;
   assign w_aw_hs   = axi_if_awvalid & r_awready;
   assign w_w_hs    = axi_if_wvalid & r_wready;
   assign w_aw_next = r_aw_held | w_aw_hs;
   assign w_w_next  = r_w_held | w_w_hs;
   assign w_wr_ctrl = r_awaddr[ADDR_WIDTH-1];
   assign w_wr_rst  = w_wr_ctrl & (r_awaddr[ADDR_WIDTH-2:2] == OW'(CTRL_CORE_RST >> 2));
   assign w_wr_scr  = w_wr_ctrl & (r_awaddr[ADDR_WIDTH-2:2] == OW'(CTRL_SCRATCH >> 2));
   assign w_rd_ctrl = r_araddr[ADDR_WIDTH-1];
   assign w_rd_rst  = w_rd_ctrl & (r_araddr[ADDR_WIDTH-2:2] == OW'(CTRL_CORE_RST >> 2));
   assign w_rd_sts  = w_rd_ctrl & (r_araddr[ADDR_WIDTH-2:2] == OW'(CTRL_STATUS >> 2));
   assign w_rd_scr  = w_rd_ctrl & (r_araddr[ADDR_WIDTH-2:2] == OW'(CTRL_SCRATCH >> 2));
   assign w_unused  = ^{r_awaddr[1:0], r_araddr[1:0]};
   for (genvar b = 0; b < NB; b++) begin : g_mask
      assign w_bmask[b*8 +: 8] = {8{r_wstrb[b]}};
   end
   assign w_ctrl_rdata = w_rd_rst ? DATA_WIDTH'(r_core_rst) :
                         w_rd_sts ? DATA_WIDTH'(w_core_reset) :
                         w_rd_scr ? r_scratch : '0;
   // The write owns the shared memory port whenever both FSMs want it in the same cycle.
   assign w_mem_wen = (r_wstate == W_EXEC) & !w_wr_ctrl;
   assign w_mem_ren = (r_rstate == R_ISSUE) & !w_rd_ctrl & !w_mem_wen;
   assign mem_wen   = w_mem_wen;
   assign mem_ren   = w_mem_ren;
   assign mem_addr  = w_mem_wen ? r_awaddr[ADDR_WIDTH-2:LSB] : w_mem_ren ? r_araddr[ADDR_WIDTH-2:LSB] : '0;
   assign mem_wstrb = w_mem_wen ? r_wstrb : '0;
   assign mem_wdata = w_mem_wen ? r_wdata : '0;
   always_ff @(posedge riscv_cpu_clk or posedge riscv_cpu_reset) begin
      if (riscv_cpu_reset) begin
         r_wstate   <= W_IDLE;
         r_aw_held  <= 1'b0;
         r_w_held   <= 1'b0;
         r_awready  <= 1'b0;
         r_wready   <= 1'b0;
         r_bvalid   <= 1'b0;
         r_bresp    <= OKAY;
         r_awaddr   <= '0;
         r_wdata    <= '0;
         r_wstrb    <= '0;
         r_core_rst <= '1;
         r_scratch  <= '0;
      end else begin
         case (r_wstate)
            W_IDLE: begin
               if (w_aw_hs) begin
                  r_awaddr  <= axi_if_awaddr;
                  r_aw_held <= 1'b1;
               end
               if (w_w_hs) begin
                  r_wdata  <= axi_if_wdata;
                  r_wstrb  <= axi_if_wstrb;
                  r_w_held <= 1'b1;
               end
               r_awready <= !w_aw_next;
               r_wready  <= !w_w_next;
               if (w_aw_next && w_w_next) r_wstate <= W_EXEC;
            end
            W_EXEC: begin
               if (w_wr_rst) r_core_rst <= (r_core_rst & ~w_bmask[NUM_CORES-1:0]) | (r_wdata[NUM_CORES-1:0] & w_bmask[NUM_CORES-1:0]);
               if (w_wr_scr) r_scratch <= (r_scratch & ~w_bmask) | (r_wdata & w_bmask);
               r_bresp  <= (w_wr_ctrl && !w_wr_rst && !w_wr_scr) ? SLVERR : OKAY;
               r_bvalid <= 1'b1;
               r_wstate <= W_RESP;
            end
            W_RESP: if (axi_if_bready) begin
               r_bvalid  <= 1'b0;
               r_aw_held <= 1'b0;
               r_w_held  <= 1'b0;
               r_awready <= 1'b1;
               r_wready  <= 1'b1;
               r_wstate  <= W_IDLE;
            end
            default: r_wstate <= W_IDLE;
         endcase
      end
   end
   always_ff @(posedge riscv_cpu_clk or posedge riscv_cpu_reset) begin
      if (riscv_cpu_reset) begin
         r_rstate  <= R_IDLE;
         r_arready <= 1'b0;
         r_rvalid  <= 1'b0;
         r_rresp   <= OKAY;
         r_rdata   <= '0;
         r_araddr  <= '0;
      end else begin
         case (r_rstate)
            R_IDLE: if (axi_if_arvalid && r_arready) begin
               r_araddr  <= axi_if_araddr;
               r_arready <= 1'b0;
               r_rstate  <= R_ISSUE;
            end else r_arready <= 1'b1;
            R_ISSUE: if (w_rd_ctrl) begin
               r_rdata  <= w_ctrl_rdata;
               r_rresp  <= (w_rd_rst || w_rd_sts || w_rd_scr) ? OKAY : SLVERR;
               r_rvalid <= 1'b1;
               r_rstate <= R_DATA;
            end else if (!w_mem_wen) r_rstate <= R_WAIT;
            R_WAIT: begin
               r_rdata  <= mem_rdata;
               r_rresp  <= OKAY;
               r_rvalid <= 1'b1;
               r_rstate <= R_DATA;
            end
            R_DATA: if (axi_if_rready) begin
               r_rvalid  <= 1'b0;
               r_arready <= 1'b1;
               r_rstate  <= R_IDLE;
            end
            default: r_rstate <= R_IDLE;
         endcase
      end
   end
   for (genvar c = 0; c < NUM_CORES; c++) begin : g_core
      riscv_rst_sync #(.STAGES(RST_SYNC_STAGES)) u_rst_sync (
         .clk     (riscv_cpu_clk),
         .arst    (riscv_cpu_reset),
         .hold_in (r_core_rst[c]),
         .rst_out (w_core_reset[c])
      );
   end
   assign core_reset     = w_core_reset;
   assign axi_if_awready = r_awready;
   assign axi_if_wready  = r_wready;
   assign axi_if_bvalid  = r_bvalid;
   assign axi_if_bresp   = r_bresp;
   assign axi_if_arready = r_arready;
   assign axi_if_rvalid  = r_rvalid;
   assign axi_if_rresp   = r_rresp;
   assign axi_if_rdata   = r_rdata;
endmodule

// File: tb/tb_riscv_cpu_axi_ctrl.sv
// tb_riscv_cpu_axi_ctrl: directed AXI-Lite vectors against a two-core, three-stage instance
// with a small registered-read memory model on the CPU memory port.
module tb_riscv_cpu_axi_ctrl;
   logic        clk, rst;
   logic [13:0] awaddr, araddr;
   logic        awvalid, awready, wvalid, wready, bvalid, bready, arvalid, arready, rvalid, rready;
   logic [31:0] wdata, rdata, mem_wdata, mem_rdata;
   logic [3:0]  wstrb, mem_wstrb;
   logic [1:0]  bresp, rresp, core_reset;
   logic [10:0] mem_addr;
   logic        mem_wen, mem_ren;
   logic [31:0] mem [0:63];
   int          cyc = 0, n_chk = 0, n_err = 0;
   int          n_wen = 0, n_ren = 0, wen_cyc = -1, ren_cyc = -1, wen_addr = -1;
   logic [3:0]  wen_strb;
   logic [31:0] wen_data;

   riscv_cpu_axi_ctrl #(.ADDR_WIDTH(14), .DATA_WIDTH(32), .NUM_CORES(2), .RST_SYNC_STAGES(3)) dut (
      .riscv_cpu_clk(clk), .riscv_cpu_reset(rst),
      .axi_if_awaddr(awaddr), .axi_if_awvalid(awvalid), .axi_if_awready(awready),
      .axi_if_wdata(wdata), .axi_if_wstrb(wstrb), .axi_if_wvalid(wvalid), .axi_if_wready(wready),
      .axi_if_bresp(bresp), .axi_if_bvalid(bvalid), .axi_if_bready(bready),
      .axi_if_araddr(araddr), .axi_if_arvalid(arvalid), .axi_if_arready(arready),
      .axi_if_rdata(rdata), .axi_if_rresp(rresp), .axi_if_rvalid(rvalid), .axi_if_rready(rready),
      .mem_addr(mem_addr), .mem_wen(mem_wen), .mem_wstrb(mem_wstrb), .mem_wdata(mem_wdata),
      .mem_ren(mem_ren), .mem_rdata(mem_rdata), .core_reset(core_reset)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // Memory model: word 4 starts at 0x11223344, every other word at 0xA50000nn.
   always @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < 64; i++) mem[i] <= (i == 4) ? 32'h11223344 : (32'hA5000000 | 32'(i));
      end else begin
         if (mem_wen)
            for (int b = 0; b < 4; b++) if (mem_wstrb[b]) mem[mem_addr[5:0]][b*8 +: 8] <= mem_wdata[b*8 +: 8];
         if (mem_ren) mem_rdata <= mem[mem_addr[5:0]];
      end
   end

   always @(negedge clk) begin
      if (mem_wen) begin
         n_wen++; wen_cyc = cyc; wen_addr = int'(mem_addr); wen_strb = mem_wstrb; wen_data = mem_wdata;
      end
      if (mem_ren) begin
         n_ren++; ren_cyc = cyc;
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation still running at %0t, limit 200000", $time);
      $fatal(1);
   end

   task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic axi_write(input logic [13:0] a, input logic [31:0] d, input logic [3:0] s, input int lead,
                            output logic [1:0] resp, output int hs_c, output int b_c);
      bit aw_done = 0, w_done = 0, got_b = 0, hs_aw, hs_w;
      hs_c = -1; b_c = -1; resp = 2'b11;
      awaddr = a; wdata = d; wstrb = s; wvalid = 1'b1; awvalid = 1'b0; bready = 1'b1;
      for (int i = 0; i < 40 && !(aw_done && w_done); i++) begin
         if (i >= lead && !aw_done) awvalid = 1'b1;
         hs_aw = awvalid & awready;
         hs_w  = wvalid & wready;
         if (hs_aw || hs_w) hs_c = cyc;
         tick;
         if (hs_aw) begin aw_done = 1; awvalid = 1'b0; end
         if (hs_w)  begin w_done = 1;  wvalid = 1'b0; end
      end
      for (int i = 0; i < 20 && !got_b; i++) begin
         if (bvalid) begin got_b = 1; b_c = cyc; resp = bresp; end
         tick;
      end
      chk("bvalid_seen", got_b, 1);
   endtask

   task automatic axi_read(input logic [13:0] a, input int hold, input logic [31:0] exp_d,
                           output logic [31:0] d, output logic [1:0] resp, output int hs_c, output int rv_c);
      bit got_a = 0, got_r = 0;
      hs_c = -1; rv_c = -1; d = '0; resp = 2'b11;
      araddr = a; arvalid = 1'b1; rready = 1'b0;
      for (int i = 0; i < 20 && !got_a; i++) begin
         if (arready) begin got_a = 1; hs_c = cyc; end
         tick;
      end
      arvalid = 1'b0;
      chk("arready_seen", got_a, 1);
      for (int i = 0; i < 20 && !got_r; i++) begin
         if (rvalid) begin got_r = 1; rv_c = cyc; d = rdata; resp = rresp; end
         else tick;
      end
      chk("rvalid_seen", got_r, 1);
      for (int i = 0; i < hold; i++) begin
         tick;
         chk("r_hold_valid", rvalid, 1);
         chk("r_hold_data", rdata, exp_d);
      end
      rready = 1'b1;
      tick;
      rready = 1'b0;
   endtask

   initial begin
      logic [1:0]  wr, rr;
      logic [31:0] d;
      int          whs, wbc, rhs, rv, base_w, base_r;
      bit          got;
      rst = 1'b1; awvalid = 0; wvalid = 0; arvalid = 0; bready = 1; rready = 0;
      awaddr = '0; araddr = '0; wdata = '0; wstrb = '0;
      repeat (3) tick;
      // 1: reset state, then readies one cycle after release, cores stay held
      chk("rst_awready", awready, 0);
      chk("rst_arready", arready, 0);
      chk("rst_bvalid", bvalid, 0);
      chk("rst_rvalid", rvalid, 0);
      chk("rst_resp", {bresp, rresp}, 4'b0000);
      chk("rst_rdata", rdata, 0);
      chk("rst_mem", {mem_wen, mem_ren, mem_addr}, 0);
      chk("rst_core_reset", core_reset, 2'b11);
      rst = 1'b0;
      chk("rel_wready_same_cycle", wready, 0);
      tick;
      chk("rel_readies", {awready, wready, arready}, 3'b111);
      repeat (10) tick;
      chk("idle_core_reset", core_reset, 2'b11);
      // 2: release both cores; W_EXEC is one cycle after the last handshake
      axi_write(14'h2000, 32'h0, 4'h1, 0, wr, whs, wbc);
      chk("core_rst_wr_resp", wr, 2'b00);
      chk("core_rst_b_lat", wbc - whs, 2);
      while (cyc < whs + 4) tick;
      chk("core_reset_exec_p3", core_reset, 2'b11);
      tick;
      chk("core_reset_exec_p4", core_reset, 2'b00);
      axi_read(14'h2004, 0, 32'h0, d, rr, rhs, rv);
      chk("status_rdata", d, 32'h0);
      chk("status_rresp", rr, 2'b00);
      chk("ctrl_rd_lat", rv - rhs, 2);
      // 3: mem write, W leads AW by 2 cycles
      base_w = n_wen;
      axi_write(14'h0010, 32'hDEADBEEF, 4'b0011, 2, wr, whs, wbc);
      chk("memwr_count", n_wen - base_w, 1);
      chk("memwr_addr", wen_addr, 4);
      chk("memwr_strb", wen_strb, 4'b0011);
      chk("memwr_data", wen_data, 32'hDEADBEEF);
      chk("memwr_wen_lat", wen_cyc - whs, 1);
      chk("memwr_b_lat", wbc - whs, 2);
      chk("memwr_bresp", wr, 2'b00);
      // 4: mem read with rready held low 5 cycles
      base_r = n_ren;
      axi_read(14'h0010, 5, 32'h1122BEEF, d, rr, rhs, rv);
      chk("memrd_data", d, 32'h1122BEEF);
      chk("memrd_rresp", rr, 2'b00);
      chk("memrd_count", n_ren - base_r, 1);
      chk("memrd_ren_lat", ren_cyc - rhs, 1);
      chk("memrd_rv_lat", rv - rhs, 3);
      // 5: write and read issue in the same cycle on the memory port
      fork
         axi_write(14'h0024, 32'hCAFEF00D, 4'hF, 0, wr, whs, wbc);
         axi_read(14'h0020, 0, 32'h0, d, rr, rhs, rv);
      join
      chk("coll_same_hs", rhs, whs);
      chk("coll_wen_cyc", wen_cyc - whs, 1);
      chk("coll_ren_cyc", ren_cyc - whs, 2);
      chk("coll_bresp", wr, 2'b00);
      chk("coll_rresp", rr, 2'b00);
      chk("coll_rdata", d, 32'hA5000008);
      chk("coll_rv_lat", rv - rhs, 4);
      axi_read(14'h0024, 0, 32'h0, d, rr, rhs, rv);
      chk("coll_readback", d, 32'hCAFEF00D);
      // 6: hold core 0 again, error responses, scratch byte enables
      axi_write(14'h2000, 32'h1, 4'h1, 0, wr, whs, wbc);
      chk("hold_core0", core_reset, 2'b01);
      axi_write(14'h2004, 32'hFF, 4'hF, 0, wr, whs, wbc);
      chk("status_wr_slverr", wr, 2'b10);
      axi_read(14'h200C, 0, 32'h0, d, rr, rhs, rv);
      chk("bad_rd_slverr", rr, 2'b10);
      chk("bad_rd_data", d, 32'h0);
      axi_read(14'h2004, 0, 32'h0, d, rr, rhs, rv);
      chk("status_unchanged", d, 32'h1);
      axi_write(14'h2008, 32'hAABBCCDD, 4'b0101, 0, wr, whs, wbc);
      axi_read(14'h2008, 0, 32'h0, d, rr, rhs, rv);
      chk("scratch_strb", d, 32'h00BB00DD);
      // async reset while the read waits on memory data
      araddr = 14'h0010; arvalid = 1'b1; got = 0;
      for (int i = 0; i < 20 && !got; i++) begin
         if (arready) got = 1;
         tick;
      end
      arvalid = 1'b0;
      chk("rstw_ar_seen", got, 1);
      chk("rstw_issue_ren", mem_ren, 1);
      tick;
      #2 rst = 1'b1;
      #1;
      chk("rstw_rvalid", rvalid, 0);
      chk("rstw_arready", arready, 0);
      chk("rstw_core_reset", core_reset, 2'b11);
      tick;
      rst = 1'b0;
      rready = 1'b1;
      repeat (4) tick;
      chk("rstw_dropped", rvalid, 0);
      chk("rstw_arready_back", arready, 1);
      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end
endmodule
